// File: rtl/store_unit.sv
// RV32I store path: forms word address, lane-shifted data and byte enables, holds the write until mem_resp.
// Optional STORE_MISALIGN_SPLIT_EN: misaligned SH/SW are legal; word-crossing stores use a second access (WR1).
module store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write,
    input  logic        mem_resp,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR0   = 2'd1,
        WR1   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  be_d;
    logic        write_d, done_d, err_d;

    logic [1:0]  off;
    logic [3:0]  mask;
    logic        illegal, misalign;
    logic [3:0]  lo_be;
    logic [31:0] lo_wdata;

    assign off = req_addr[1:0];

    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (req_funct3)
            3'b000:  mask = 4'b0001;
            3'b001:  mask = 4'b0011;
            3'b010:  mask = 4'b1111;
            default: illegal = 1'b1;
        endcase
    end

`ifdef STORE_MISALIGN_SPLIT_EN
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic [3:0]  hi_be_q, hi_be_d;
    logic [31:0] hi_wdata_q, hi_wdata_d;
    logic        cross_q, cross_d;

    // Shifting into a double-width window yields both accesses at once:
    // the upper half is exactly (mask<<off)[7:4] and data >> 8*(4-off).
    assign be_wide    = {4'b0000, mask} << off;
    assign wdata_wide = {32'h0, req_data} << {off, 3'b000};
    assign lo_be      = be_wide[3:0];
    assign lo_wdata   = wdata_wide[31:0];
    assign misalign   = 1'b0;
`else
    assign lo_be      = mask << off;
    assign lo_wdata   = req_data << {off, 3'b000};
    assign misalign   = ((req_funct3 == 3'b001) && req_addr[0]) ||
                        ((req_funct3 == 3'b010) && (off != 2'b00));
`endif

    assign req_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        addr_d  = mem_address;
        wdata_d = mem_wdata;
        be_d    = mem_byte_enable;
        write_d = mem_write;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        hi_be_d    = hi_be_q;
        hi_wdata_d = hi_wdata_q;
        cross_d    = cross_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (illegal || misalign) begin
                        state_d = FAULT;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WR0;
                        write_d = 1'b1;
                        addr_d  = {req_addr[31:2], 2'b00};
                        be_d    = lo_be;
                        wdata_d = lo_wdata;
`ifdef STORE_MISALIGN_SPLIT_EN
                        hi_be_d    = be_wide[7:4];
                        hi_wdata_d = wdata_wide[63:32];
                        cross_d    = |be_wide[7:4];
`endif
                    end
                end
            end
            WR0: begin
                if (mem_resp) begin
`ifdef STORE_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        state_d = WR1;
                        addr_d  = mem_address + 32'd4;
                        be_d    = hi_be_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        state_d = IDLE;
                        write_d = 1'b0;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    write_d = 1'b0;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            WR1: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    write_d = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            FAULT:   state_d = IDLE;
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
            mem_write       <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_address     <= addr_d;
            mem_wdata       <= wdata_d;
            mem_byte_enable <= be_d;
            mem_write       <= write_d;
            done            <= done_d;
            err             <= err_d;
        end
    end

`ifdef STORE_MISALIGN_SPLIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_be_q    <= '0;
            hi_wdata_q <= '0;
            cross_q    <= 1'b0;
        end else begin
            hi_be_q    <= hi_be_d;
            hi_wdata_q <= hi_wdata_d;
            cross_q    <= cross_d;
        end
    end
`endif

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; split-store cases build only with STORE_MISALIGN_SPLIT_EN.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_write;
    logic        mem_resp;
    logic        done;
    logic        err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_write       (mem_write),
        .mem_resp        (mem_resp),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle; it is accepted at the next edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_data   = d;
        chk("ready_before_accept", {31'b0, req_ready}, 32'd1);
        step();
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_data   = '0;
    endtask

    // One memory access held for 'hold' cycles; mem_resp asserted in the last.
    task automatic access(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input int unsigned hold);
        for (int unsigned i = 0; i < hold; i++) begin
            chk({tag, "_write"}, {31'b0, mem_write}, 32'd1);
            chk({tag, "_addr"}, mem_address, ea);
            chk({tag, "_be"}, {28'b0, mem_byte_enable}, {28'b0, ebe});
            chk({tag, "_wdata"}, mem_wdata, ewd);
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
            chk({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
            if (i == hold - 1) mem_resp = 1'b1;
            step();
            mem_resp = 1'b0;
        end
    endtask

    task automatic retired(input string tag, input logic eerr);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, eerr});
        chk({tag, "_write_low"}, {31'b0, mem_write}, 32'd0);
    endtask

    task automatic fault_case(input string tag, input logic [2:0] f3, input logic [31:0] a);
        issue(f3, a, 32'hCAFEF00D);
        retired(tag, 1'b1);
        chk({tag, "_ready_low"}, {31'b0, req_ready}, 32'd0);
        step();
        chk({tag, "_done_clr"}, {31'b0, done}, 32'd0);
        chk({tag, "_err_clr"}, {31'b0, err}, 32'd0);
        chk({tag, "_nowrite"}, {31'b0, mem_write}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_data   = '0;
        mem_resp   = 1'b0;
        #1;
        chk("rst_write", {31'b0, mem_write}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'b0, mem_byte_enable}, 32'h0);
        #12 rst_n = 1'b1;
        step();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);

        // SW held three cycles
        issue(3'b010, 32'h0000_1000, 32'hDEAD_BEEF);
        access("sw", 32'h0000_1000, 4'b1111, 32'hDEAD_BEEF, 3);
        retired("sw", 1'b0);
        chk("sw_ready_at_done", {31'b0, req_ready}, 32'd1);
        step();
        chk("sw_done_pulse", {31'b0, done}, 32'd0);

        // SB top lane, minimum latency, then SH issued in the done cycle
        issue(3'b000, 32'h0000_2003, 32'h0000_00A5);
        access("sb", 32'h0000_2000, 4'b1000, 32'hA500_0000, 1);
        retired("sb", 1'b0);
        issue(3'b001, 32'h0000_2002, 32'h0000_1234);
        access("sh", 32'h0000_2000, 4'b1100, 32'h1234_0000, 1);
        retired("sh", 1'b0);
        step();

        fault_case("f3_011", 3'b011, 32'h0000_2000);
        fault_case("f3_111", 3'b111, 32'h0000_2004);

`ifdef STORE_MISALIGN_SPLIT_EN
        issue(3'b010, 32'h0000_2001, 32'h1122_3344);
        access("split_sw_a", 32'h0000_2000, 4'b1110, 32'h2233_4400, 1);
        access("split_sw_b", 32'h0000_2004, 4'b0001, 32'h0000_0011, 2);
        retired("split_sw", 1'b0);
        step();

        issue(3'b001, 32'hFFFF_FFFF, 32'h0000_ABCD);
        access("split_sh_a", 32'hFFFF_FFFC, 4'b1000, 32'hCD00_0000, 1);
        access("split_sh_b", 32'h0000_0000, 4'b0001, 32'h0000_00AB, 1);
        retired("split_sh", 1'b0);
        step();

        issue(3'b001, 32'h0000_4001, 32'h0000_BEEF);
        access("sh_off1", 32'h0000_4000, 4'b0110, 32'h00BE_EF00, 1);
        retired("sh_off1", 1'b0);
        step();
`else
        fault_case("mis_sw", 3'b010, 32'h0000_2001);
        fault_case("mis_sh", 3'b001, 32'h0000_2003);
`endif

        // Reset in the middle of a held write
        issue(3'b010, 32'h0000_3000, 32'h5555_AAAA);
        chk("mid_write_high", {31'b0, mem_write}, 32'd1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_write_async_low", {31'b0, mem_write}, 32'd0);
        chk("mid_addr_cleared", mem_address, 32'h0);
        chk("mid_no_done", {31'b0, done}, 32'd0);
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_no_done", {31'b0, done}, 32'd0);
        chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
        issue(3'b000, 32'h0000_3001, 32'h0000_0077);
        access("post_rst_sb", 32'h0000_3000, 4'b0010, 32'h0000_7700, 2);
        retired("post_rst_sb", 1'b0);
        step();

        // Stray acknowledge while idle changes nothing
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0;
        chk("stray_write", {31'b0, mem_write}, 32'd0);
        chk("stray_done", {31'b0, done}, 32'd0);
        chk("stray_err", {31'b0, err}, 32'd0);
        chk("stray_addr", mem_address, 32'h0000_3000);
        chk("stray_be", {28'b0, mem_byte_enable}, 32'h2);
        chk("stray_ready", {31'b0, req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
